// File: rtl/demux_bin_reg.sv
// One-entry registered demux: a transfer is steered to the o_vld bit picked by bin, one cycle later.
// i_rdy follows the selected channel's o_rdy while full; optional err port via DEMUX_BIN_REG_ERR_EN.
module demux_bin_reg #(
  parameter type DAT_T = logic [8-1:0],
  parameter int WIDTH = 32,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_vld,
  output logic                 i_rdy,
  input  logic [WIDTH_LOG-1:0] bin,
  input  DAT_T                 i_dat,
  output logic [WIDTH-1:0]     o_vld,
  input  logic [WIDTH-1:0]     o_rdy,
  output DAT_T                 o_dat
`ifdef DEMUX_BIN_REG_ERR_EN
  ,
  output logic                 err
`endif
);

  generate
    if (WIDTH < 2) begin : g_width_chk
      $fatal(1, "demux_bin_reg: WIDTH must be at least 2");
    end
  endgenerate

  logic                 full;
  logic [WIDTH_LOG-1:0] sel;
  DAT_T                 data;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 in_range;
  logic [31:0]          bin_ext;

  assign bin_ext  = 32'(bin);
  assign in_range = (bin_ext < 32'(WIDTH));
  assign out_xfer = full && o_rdy[sel];
  assign i_rdy    = !full || o_rdy[sel];
  assign in_xfer  = i_vld && i_rdy;
  assign o_dat    = data;

  always_comb begin
    o_vld = '0;
    if (full) o_vld[sel] = 1'b1;
  end

  // An out-of-range transfer is consumed but never occupies the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (in_xfer && in_range) begin
      full <= 1'b1;
    end else if (out_xfer) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer && in_range) begin
      sel  <= bin;
      data <= i_dat;
    end
  end

`ifdef DEMUX_BIN_REG_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= in_xfer && !in_range;
    end
  end
`endif

endmodule

// File: tb/tb_demux_bin_reg.sv
// Scoreboard bench for demux_bin_reg: WIDTH=32 instance for data paths, WIDTH=5 for out-of-range selects.
module tb_demux_bin_reg;

  logic        clk;
  logic        rst_n;
  logic        i_vld, i_rdy;
  logic [4:0]  bin;
  logic [7:0]  i_dat, o_dat;
  logic [31:0] o_vld, o_rdy;

  logic        b_i_vld, b_i_rdy;
  logic [2:0]  b_bin;
  logic [7:0]  b_i_dat, b_o_dat;
  logic [4:0]  b_o_vld, b_o_rdy;
`ifdef DEMUX_BIN_REG_ERR_EN
  logic        err, b_err;
`endif

  typedef struct packed {
    int         cyc;
    logic [4:0] ch;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   presenting = 0;

  demux_bin_reg #(.DAT_T(logic [7:0]), .WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(i_rdy), .bin(bin), .i_dat(i_dat),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat)
`ifdef DEMUX_BIN_REG_ERR_EN
    , .err(err)
`endif
  );

  demux_bin_reg #(.DAT_T(logic [7:0]), .WIDTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_vld(b_i_vld), .i_rdy(b_i_rdy), .bin(b_bin), .i_dat(b_i_dat),
    .o_vld(b_o_vld), .o_rdy(b_o_rdy), .o_dat(b_o_dat)
`ifdef DEMUX_BIN_REG_ERR_EN
    , .err(b_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Drive one transfer at posedge+1; record the cycle in which its output must appear.
  task automatic send(input logic [4:0] b, input logic [7:0] d);
    exp_t e;
    i_vld = 1'b1;
    bin   = b;
    i_dat = d;
    @(negedge clk);
    chk("send_i_rdy", {31'b0, i_rdy}, 32'd1);
    @(posedge clk);
    #1;
    e.cyc = cyc;
    e.ch  = b;
    e.d   = d;
    exp_q.push_back(e);
    i_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      presenting = 0;
    end else begin
      chk("onehot", {31'b0, $onehot0(o_vld)}, 32'd1);
      if (o_vld != 0 && !presenting) begin
        presenting = 1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_vld: got o_vld=%0h expected none", o_vld);
        end else begin
          chk("latency_cycle", cyc, exp_q[0].cyc);
        end
      end
      if ((o_vld & o_rdy) != 0) begin
        presenting = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_xfer: got o_vld=%0h expected no transfer", o_vld);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_chan", o_vld, 32'd1 << e.ch);
          chk("xfer_data", {24'b0, o_dat}, {24'b0, e.d});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i_vld = 1'b0; bin = '0; i_dat = '0; o_rdy = '1;
    b_i_vld = 1'b0; b_bin = '0; b_i_dat = '0; b_o_rdy = '1;
    #2;
    chk("rst_o_vld", o_vld, 32'd0);
    chk("rst_i_rdy", {31'b0, i_rdy}, 32'd1);
    chk("rst_b_o_vld", {27'b0, b_o_vld}, 32'd0);
`ifdef DEMUX_BIN_REG_ERR_EN
    chk("rst_err", {31'b0, b_err}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_o_vld", o_vld, 32'd0);
    end

    // single transfer to channel 7
    @(posedge clk); #1;
    send(5'd7, 8'hA5);
    @(negedge clk);
    chk("single_o_vld", o_vld, 32'h0000_0080);
    chk("single_o_dat", {24'b0, o_dat}, 32'hA5);
    @(negedge clk);
    chk("single_drop", o_vld, 32'd0);

    // back-to-back to different channels
    @(posedge clk); #1;
    send(5'd3, 8'h11);
    send(5'd4, 8'h22);
    send(5'd5, 8'h33);
    repeat (2) @(negedge clk);
    chk("b2b_drain", o_vld, 32'd0);

    // stall on channel 2, other readies high
    @(posedge clk); #1;
    o_rdy = ~32'h4;
    send(5'd2, 8'h5A);
    repeat (5) begin
      @(negedge clk);
      chk("stall_i_rdy", {31'b0, i_rdy}, 32'd0);
      chk("stall_o_vld", o_vld, 32'h4);
      chk("stall_o_dat", {24'b0, o_dat}, 32'h5A);
    end
    @(posedge clk); #1;
    o_rdy = '1;
    @(negedge clk);
    chk("release_i_rdy", {31'b0, i_rdy}, 32'd1);
    @(negedge clk);
    chk("release_drop", o_vld, 32'd0);

    // WIDTH=5: valid entry drains while an out-of-range select arrives
    @(posedge clk); #1;
    b_i_vld = 1'b1; b_bin = 3'd1; b_i_dat = 8'h10;
    @(negedge clk);
    chk("b_in_rdy", {31'b0, b_i_rdy}, 32'd1);
    @(posedge clk); #1;
    b_bin = 3'd7; b_i_dat = 8'hEE;
    @(negedge clk);
    chk("b_o_vld1", {27'b0, b_o_vld}, 32'h2);
    chk("b_o_dat1", {24'b0, b_o_dat}, 32'h10);
    chk("b_oor_rdy1", {31'b0, b_i_rdy}, 32'd1);
    @(posedge clk); #1;
    b_i_vld = 1'b0;
    @(negedge clk);
    chk("b_oor_empty1", {27'b0, b_o_vld}, 32'd0);
`ifdef DEMUX_BIN_REG_ERR_EN
    chk("b_err_pulse1", {31'b0, b_err}, 32'd1);
`endif
    // out-of-range select while empty
    @(posedge clk); #1;
    b_i_vld = 1'b1; b_bin = 3'd6; b_i_dat = 8'h99;
    @(negedge clk);
    chk("b_oor_rdy2", {31'b0, b_i_rdy}, 32'd1);
`ifdef DEMUX_BIN_REG_ERR_EN
    chk("b_err_low", {31'b0, b_err}, 32'd0);
`endif
    @(posedge clk); #1;
    b_i_vld = 1'b0;
    @(negedge clk);
    chk("b_oor_empty2", {27'b0, b_o_vld}, 32'd0);
`ifdef DEMUX_BIN_REG_ERR_EN
    chk("b_err_pulse2", {31'b0, b_err}, 32'd1);
`endif
    @(negedge clk);
    chk("b_oor_empty3", {27'b0, b_o_vld}, 32'd0);
`ifdef DEMUX_BIN_REG_ERR_EN
    chk("b_err_clear", {31'b0, b_err}, 32'd0);
`endif

    // reset while holding a stalled entry
    @(posedge clk); #1;
    o_rdy = ~32'h200;
    send(5'd9, 8'hC3);
    @(negedge clk);
    chk("pre_rst_o_vld", o_vld, 32'h200);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_o_vld", o_vld, 32'd0);
    chk("async_rst_i_rdy", {31'b0, i_rdy}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    o_rdy = '1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_o_vld", o_vld, 32'd0);
    end

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_bin_reg.md
DEMUX_BIN_REG -- requirements
Module: demux_bin_reg

Interface
REQ-001 SHALL have parameter DAT_T, default logic [8-1:0], data type carried per transfer.
REQ-002 SHALL have parameter WIDTH, default 32, number of output channels; WIDTH < 2 SHALL raise $fatal at elaboration.
REQ-003 SHALL have localparam WIDTH_LOG = $clog2(WIDTH), select width.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_vld  input  1  input transfer valid.
REQ-007 SHALL have port i_rdy  output  1  input transfer ready.
REQ-008 SHALL have port bin  input  WIDTH_LOG  binary channel select, qualified by i_vld.
REQ-009 SHALL have port i_dat  input  DAT_T  input data, qualified by i_vld.
REQ-010 SHALL have port o_vld  output  [WIDTH-1:0]  per-channel output valid.
REQ-011 SHALL have port o_rdy  input  [WIDTH-1:0]  per-channel output ready.
REQ-012 SHALL have port o_dat  output  DAT_T  registered data, shared by all channels.

Function
REQ-013 SHALL hold one entry: full flag, registered select sel (WIDTH_LOG bits), registered data.
REQ-014 Input transfer SHALL occur on a cycle with i_vld && i_rdy; output transfer on channel k on a cycle with o_vld[k] && o_rdy[k].
REQ-015 o_vld[k] SHALL equal full && (sel == k); at most one bit of o_vld is ever set.
REQ-016 o_dat SHALL equal the data register whenever full; value while empty is don't-care, but SHALL be stable while full.
REQ-017 i_rdy SHALL equal !full || o_rdy[sel] (combinational pass-through of the selected channel's ready); i_rdy SHALL NOT depend on i_vld or bin.
REQ-018 Latency from input transfer to o_vld SHALL be exactly 1 cycle; throughput 1 transfer/cycle when the selected o_rdy stays high, including consecutive transfers to different channels.
REQ-019 Empty state: input transfer with bin < WIDTH SHALL set full and load sel and data.
REQ-020 Full state, output transfer without input transfer: full SHALL clear.
REQ-021 Full state, simultaneous output and input transfer: full SHALL stay set and sel/data SHALL reload from the new transfer in the same edge.
REQ-022 Full state, o_rdy[sel] low: i_rdy SHALL be low; sel and data SHALL hold; ready on non-selected channels SHALL have no effect.
REQ-023 Input transfer with bin >= WIDTH (possible only when WIDTH is not a power of two) SHALL be accepted and discarded: it does not load sel/data or set full, and it still acts as the input side of REQ-020 (full clears if the output also transferred).

Reset
REQ-024 On rst_n low, full SHALL clear asynchronously; o_vld SHALL be all zeros immediately and i_rdy SHALL be 1.
REQ-025 sel and data registers SHALL NOT require reset.
REQ-026 An entry held when reset asserts mid-operation SHALL be lost; no o_vld SHALL pulse after reset deassertion until a new input transfer.

Configuration
REQ-027 Macro DEMUX_BIN_REG_ERR_EN SHALL compile in the port err  output  1  out-of-range select flag.
REQ-028 With DEMUX_BIN_REG_ERR_EN defined, err SHALL be a registered one-cycle pulse the cycle after each input transfer with bin >= WIDTH; reset value 0.
REQ-029 Without DEMUX_BIN_REG_ERR_EN, port err and its register SHALL be absent; discard behaviour per REQ-023 is unchanged.

Verification
REQ-030 Reset then idle: rst_n low -> o_vld=0, i_rdy=1; after release with i_vld=0 for 10 cycles -> o_vld stays 0.
REQ-031 WIDTH=32, send i_dat=0xA5, bin=7, o_rdy all 1 -> next cycle o_vld=32'h0000_0080, o_dat=0xA5; following cycle o_vld=0.
REQ-032 Back-to-back bin=3,4,5 with data 0x11,0x22,0x33, all o_rdy high -> three consecutive cycles o_vld one-hot at 3,4,5 with matching data, i_rdy constantly 1.
REQ-033 Stall: hold entry bin=2, data 0x5A, with o_rdy[2]=0 for 5 cycles and o_rdy[others]=1 -> i_rdy=0, o_vld[2]=1, o_dat=0x5A stable; raise o_rdy[2] -> transfer completes, i_rdy=1 in the same cycle.
REQ-034 WIDTH=5, send bin=6 with DEMUX_BIN_REG_ERR_EN defined -> transfer accepted (i_rdy=1), o_vld stays 0, err=1 for exactly one cycle; without the macro, same response without err.
REQ-035 Assert rst_n low while full with o_rdy[sel]=0 -> o_vld drops to 0 asynchronously, before the next clk edge; after release -> no output transfer occurs.
